// File: rtl/usb3_pkg.sv
// usb3_pkg: shared definitions for the FX3 slave-FIFO read path.
// Holds the read-controller state encoding (also decoded by the RAM-cache
// write stage, which treats ST_READ as "valid burst word") and FX3 defaults.
package usb3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHK_FLAG = 4'd1,
        ST_SEL      = 4'd2,
        ST_OE_ON    = 4'd3,
        ST_RD_ISSUE = 4'd4,
        ST_LAT_WAIT = 4'd5,
        ST_READ     = 4'd6,
        ST_CLOSE    = 4'd7,
        ST_GAP      = 4'd8
    } usb_rd_state_e;

    localparam logic [1:0] FX3_SOCK_ADDR  = 2'b11;
    localparam int         USB3_BURST_LEN = 256;
    localparam int         USB3_RD_LAT    = 2;
    localparam int         USB3_MIN_GAP   = 4;

endpackage

// File: rtl/usb3_flag_sync.sv
// usb3_flag_sync: two-flop synchroniser for the FX3 FLAGA status line.
// Ports: wrclock (clock), rst_n (async active-low reset),
//        async_in (raw flag), sync_out (synchronised flag, resets to 0).
module usb3_flag_sync (
    input  logic wrclock,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/usb3_fifo_rd_ctrl.sv
// usb3_fifo_rd_ctrl: FX3 slave-FIFO read master issuing fixed-length bursts.
// Ports: wrclock/rst_n clock and async active-low reset; enable allows bursts;
//        USB3_FLAGA FX3 DMA-ready; USB3_DQ FX3 data bus; USB3_SLCS_N, USB3_SLOE_N,
//        USB3_SLRD_N active-low FX3 strobes; USB3_A socket address; data_out and
//        data_valid captured burst word; usb_rd_state state code; burst_cnt
//        completed bursts.
module usb3_fifo_rd_ctrl
    import usb3_pkg::*;
#(
    parameter int         BURST_LEN = USB3_BURST_LEN,
    parameter int         RD_LAT    = USB3_RD_LAT,
    parameter int         MIN_GAP   = USB3_MIN_GAP,
    parameter logic [1:0] SOCK_ADDR = FX3_SOCK_ADDR
) (
    input  logic        wrclock,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        USB3_FLAGA,
    input  logic [31:0] USB3_DQ,
    output logic        USB3_SLCS_N,
    output logic        USB3_SLOE_N,
    output logic        USB3_SLRD_N,
    output logic [1:0]  USB3_A,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic [3:0]  usb_rd_state,
    output logic [15:0] burst_cnt
);

    usb_rd_state_e      state, state_nxt;
    logic               flag_sync;
    logic [RD_LAT-1:0]  issue_pipe;
    logic [31:0]        dq_q;
    logic [8:0]         rd_cnt, rd_cnt_nxt, cap_cnt;
    logic [3:0]         gap_cnt;
    logic               rd_nxt;

    usb3_flag_sync u_flag_sync (
        .wrclock  (wrclock),
        .rst_n    (rst_n),
        .async_in (USB3_FLAGA),
        .sync_out (flag_sync)
    );

    // Strobes already issued including the one on the bus this cycle.
    assign rd_cnt_nxt = rd_cnt + {8'd0, ~USB3_SLRD_N};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     state_nxt = enable ? ST_CHK_FLAG : ST_IDLE;
            ST_CHK_FLAG: state_nxt = flag_sync ? ST_SEL : (enable ? ST_CHK_FLAG : ST_IDLE);
            ST_SEL:      state_nxt = ST_OE_ON;
            ST_OE_ON:    state_nxt = ST_RD_ISSUE;
            // Pipe tail high means the word for the first strobe sits in dq_q now.
            ST_RD_ISSUE: state_nxt = issue_pipe[RD_LAT-1] ? ST_READ : ST_LAT_WAIT;
            ST_LAT_WAIT: state_nxt = issue_pipe[RD_LAT-1] ? ST_READ : ST_LAT_WAIT;
            ST_READ:     state_nxt = (cap_cnt == 9'(BURST_LEN - 1)) ? ST_CLOSE : ST_READ;
            ST_CLOSE:    state_nxt = ST_GAP;
            ST_GAP:      state_nxt = (gap_cnt == 4'(MIN_GAP - 1)) ? ST_IDLE : ST_GAP;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Strobe next cycle: always while waiting for the first word, then only
    // until exactly BURST_LEN strobes have gone out.
    assign rd_nxt = (state_nxt == ST_RD_ISSUE) || (state_nxt == ST_LAT_WAIT) ||
                    ((state_nxt == ST_READ) && (rd_cnt_nxt < 9'(BURST_LEN)));

    // Outputs are registered from state_nxt so they line up with the state register.
    always_ff @(posedge wrclock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            USB3_SLCS_N <= 1'b1;
            USB3_SLOE_N <= 1'b1;
            USB3_SLRD_N <= 1'b1;
            USB3_A      <= SOCK_ADDR;
            issue_pipe  <= '0;
            dq_q        <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            rd_cnt      <= '0;
            cap_cnt     <= '0;
            gap_cnt     <= '0;
            burst_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            USB3_SLCS_N <= !((state_nxt >= ST_SEL) && (state_nxt <= ST_READ));
            USB3_SLOE_N <= !((state_nxt >= ST_OE_ON) && (state_nxt <= ST_READ));
            USB3_SLRD_N <= !rd_nxt;
            USB3_A      <= SOCK_ADDR;
            issue_pipe  <= {issue_pipe[RD_LAT-2:0], ~USB3_SLRD_N};
            dq_q        <= USB3_DQ;
            data_valid  <= (state_nxt == ST_READ);
            if (state_nxt == ST_READ)
                data_out <= dq_q;
            rd_cnt      <= ((state_nxt >= ST_RD_ISSUE) && (state_nxt <= ST_READ)) ? rd_cnt_nxt : 9'd0;
            cap_cnt     <= (state == ST_READ) ? cap_cnt + 9'd1 : 9'd0;
            gap_cnt     <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (state_nxt == ST_CLOSE)
                burst_cnt <= burst_cnt + 16'd1;
        end
    end

    assign usb_rd_state = state;

endmodule
